i2s_tx_multi: RTL and testbench

- Parametrised I2S/serial-audio transmitter; next generation of the fixed 24-bit, div-by-2 audio DAC interface.
- Accepts stereo samples through a valid/ready stream into a small sample FIFO, then serialises them on LRCK/BCK/DATA.
- Configurable sample width, slot width and BCK divider; runtime-selectable I2S, left-justified or right-justified framing; enable gating and sticky underrun reporting.
- Sits between the audio mixer (sample producer) and the board DAC pins.

---
 rtl/audio_pkg.sv | 26 ++
 rtl/audio_sample_fifo.sv | 61 ++++++
 rtl/i2s_tx_multi.sv | 174 +++++++++++++++++
 tb/tb_i2s_tx_multi.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the serial-audio transmitter family.
package audio_pkg;

   // Frame format selector; the spare code behaves like I2S.
   typedef enum logic [1:0] {
      FMT_I2S = 2'b00,
      FMT_LJ  = 2'b01,
      FMT_RJ  = 2'b10,
      FMT_ALT = 2'b11
   } fmt_e;

   // Width of an occupancy count able to hold 0..depth.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Legal parameter combination for the transmitter.
   function automatic bit cfg_ok(input int unsigned data_w,
                                 input int unsigned slot_w,
                                 input int unsigned bck_half,
                                 input int unsigned depth);
      return (data_w >= 8) && (data_w <= 32) && (slot_w >= data_w + 1) &&
             (bck_half >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-pair FIFO with occupancy count and show-ahead read.
module audio_sample_fifo
   import audio_pkg::*;
#(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [WIDTH-1:0]          i_wdata,
   output logic [WIDTH-1:0]          o_rdata_c,
   output logic [level_w(DEPTH)-1:0] o_level,
   output logic                      o_full_c,
   output logic                      o_empty_c
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = level_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   // Qualify requests against the current occupancy.
   always_comb begin
      o_full_c  = (r_level == LW'(DEPTH));
      o_empty_c = (r_level == '0);
      w_push    = i_push && !o_full_c;
      w_pop     = i_pop && !o_empty_c;
      o_rdata_c = r_mem[r_rptr];
   end

   // Pointers and level; a push and pop together leave the level alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   assign o_level = r_level;

endmodule

// File: rtl/i2s_tx_multi.sv
// Parametrised I2S / left- / right-justified stereo transmitter with sample FIFO.
module i2s_tx_multi
   import audio_pkg::*;
#(
   parameter int unsigned DATA_W        = 24,
   parameter int unsigned SLOT_W        = 32,
   parameter int unsigned BCK_HALF      = 1,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned UNDERRUN_ZERO = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic [1:0]                     fmt,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_W-1:0]              s_left,
   input  logic [DATA_W-1:0]              s_right,
   output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
   output logic                           frame_start,
   output logic                           underrun,
   input  logic                           underrun_clr,
   output logic                           i2s_lrck,
   output logic                           i2s_bck,
   output logic                           i2s_data
);
   localparam int unsigned DIV_W  = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
   localparam int unsigned CNT_W  = $clog2(2 * SLOT_W);
   localparam int unsigned PAIR_W = 2 * DATA_W;

   if (!cfg_ok(DATA_W, SLOT_W, BCK_HALF, FIFO_DEPTH)) begin : g_bad_cfg
      $error("i2s_tx_multi: illegal parameter combination");
   end

   logic [DIV_W-1:0]  r_div;
   logic              r_bck;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_lrck;
   logic              r_frame_start;
   logic              r_underrun;
   logic [SLOT_W-1:0] r_sh;
   logic [1:0]        r_fmt;
   logic [DATA_W-1:0] r_right;
   logic [DATA_W-1:0] r_last_l;
   logic [DATA_W-1:0] r_last_r;

   logic              w_tc;
   logic              w_fall;
   logic              w_frame;
   logic              w_rslot;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [PAIR_W-1:0] w_pair;
   logic [DATA_W-1:0] w_src_l;
   logic [DATA_W-1:0] w_src_r;

   // Position a sample inside its slot for the selected framing.
   function automatic logic [SLOT_W-1:0] place(input logic [DATA_W-1:0] s, input logic [1:0] f);
      logic [SLOT_W-1:0] w;
      w = {{(SLOT_W - DATA_W){1'b0}}, s};
      case (f)
         FMT_LJ:  return w << (SLOT_W - DATA_W);
         FMT_RJ:  return w;
         default: return w << (SLOT_W - DATA_W - 1);
      endcase
   endfunction

   audio_sample_fifo #(
      .WIDTH (PAIR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (s_valid),
      .i_pop     (w_pop),
      .i_wdata   ({s_left, s_right}),
      .o_rdata_c (w_pair),
      .o_level   (fifo_level),
      .o_full_c  (w_full),
      .o_empty_c (w_empty)
   );

   // Edge/slot decode and the sample source for the next frame.
   always_comb begin
      w_tc      = (r_div == DIV_W'(BCK_HALF - 1));
      w_fall    = enable && w_tc && r_bck;
      w_cnt_nxt = (r_cnt == CNT_W'(2 * SLOT_W - 1)) ? '0 : r_cnt + CNT_W'(1);
      w_frame   = w_fall && (w_cnt_nxt == '0);
      w_rslot   = w_fall && (w_cnt_nxt == CNT_W'(SLOT_W));
      w_pop     = w_frame && !w_empty;
      w_src_l   = '0;
      w_src_r   = '0;
      if (!w_empty) begin
         w_src_l = w_pair[PAIR_W-1 -: DATA_W];
         w_src_r = w_pair[DATA_W-1:0];
      end else if (UNDERRUN_ZERO == 0) begin
         w_src_l = r_last_l;
         w_src_r = r_last_r;
      end
   end

   // BCK divider and bit counter, parked at reset values while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_bck <= 1'b0;
         r_cnt <= CNT_W'(2 * SLOT_W - 1);
      end else if (!enable) begin
         r_div <= '0;
         r_bck <= 1'b0;
         r_cnt <= CNT_W'(2 * SLOT_W - 1);
      end else if (w_tc) begin
         r_div <= '0;
         r_bck <= ~r_bck;
         if (r_bck) r_cnt <= w_cnt_nxt;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Shift register, LRCK and frame pulse, all updated on BCK falling events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh          <= '0;
         r_lrck        <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame;
         if (!enable) begin
            r_sh   <= '0;
            r_lrck <= 1'b0;
         end else if (w_fall) begin
            r_lrck <= (w_cnt_nxt >= CNT_W'(SLOT_W));
            if (w_frame)      r_sh <= place(w_src_l, fmt);
            else if (w_rslot) r_sh <= place(r_right, r_fmt);
            else              r_sh <= {r_sh[SLOT_W-2:0], 1'b0};
         end
      end
   end

   // Per-frame latches: format, held right sample, last popped pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fmt    <= FMT_I2S;
         r_right  <= '0;
         r_last_l <= '0;
         r_last_r <= '0;
      end else if (w_frame) begin
         r_fmt   <= fmt;
         r_right <= w_src_r;
         if (!w_empty) begin
            r_last_l <= w_src_l;
            r_last_r <= w_src_r;
         end
      end
   end

   // Sticky underrun; a fresh underrun wins over a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_underrun <= 1'b0;
      else if (w_frame && w_empty) r_underrun <= 1'b1;
      else if (underrun_clr)       r_underrun <= 1'b0;
   end

   assign s_ready     = !w_full;
   assign frame_start = r_frame_start;
   assign underrun    = r_underrun;
   assign i2s_lrck    = r_lrck;
   assign i2s_bck     = r_bck;
   assign i2s_data    = r_sh[SLOT_W-1];

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Scoreboard bench for i2s_tx_multi: three instances cover default, RJ/slow-BCK and repeat-on-underrun.
module tb_i2s_tx_multi;

   typedef struct packed {
      logic [31:0] l;
      logic [31:0] r;
      logic [1:0]  f;
   } ent_t;

   logic clk;
   logic rst_n;

   logic        en0, sv0, clr0, rdy0, fs0, ur0, lr0, bk0, dt0;
   logic [1:0]  fm0;
   logic [23:0] sl0, sr0;
   logic [2:0]  lv0;

   logic        en1, sv1, clr1, rdy1, fs1, ur1, lr1, bk1, dt1;
   logic [1:0]  fm1;
   logic [15:0] sl1, sr1;
   logic [2:0]  lv1;

   logic        en2, sv2, clr2, rdy2, fs2, ur2, lr2, bk2, dt2;
   logic [1:0]  fm2;
   logic [23:0] sl2, sr2;
   logic [2:0]  lv2;

   int          total;
   int          bad;
   ent_t        sb[$];
   logic [31:0] last_l [3];
   logic [31:0] last_r [3];
   logic [1:0]  last_f [3];
   longint      fs_last;
   longint      fs_prev;

   i2s_tx_multi dut0 (
      .clk(clk), .rst_n(rst_n), .enable(en0), .fmt(fm0), .s_valid(sv0), .s_ready(rdy0),
      .s_left(sl0), .s_right(sr0), .fifo_level(lv0), .frame_start(fs0), .underrun(ur0),
      .underrun_clr(clr0), .i2s_lrck(lr0), .i2s_bck(bk0), .i2s_data(dt0));

   i2s_tx_multi #(.DATA_W(16), .BCK_HALF(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(en1), .fmt(fm1), .s_valid(sv1), .s_ready(rdy1),
      .s_left(sl1), .s_right(sr1), .fifo_level(lv1), .frame_start(fs1), .underrun(ur1),
      .underrun_clr(clr1), .i2s_lrck(lr1), .i2s_bck(bk1), .i2s_data(dt1));

   i2s_tx_multi #(.UNDERRUN_ZERO(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .fmt(fm2), .s_valid(sv2), .s_ready(rdy2),
      .s_left(sl2), .s_right(sr2), .fifo_level(lv2), .frame_start(fs2), .underrun(ur2),
      .underrun_clr(clr2), .i2s_lrck(lr2), .i2s_bck(bk2), .i2s_data(dt2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic get_fs(input int w);
      case (w) 0: return fs0; 1: return fs1; default: return fs2; endcase
   endfunction
   function automatic logic get_bck(input int w);
      case (w) 0: return bk0; 1: return bk1; default: return bk2; endcase
   endfunction
   function automatic logic get_lrck(input int w);
      case (w) 0: return lr0; 1: return lr1; default: return lr2; endcase
   endfunction
   function automatic logic get_data(input int w);
      case (w) 0: return dt0; 1: return dt1; default: return dt2; endcase
   endfunction

   // Expected slot contents, slot bit 0 at [31], built bit by bit from the framing rules.
   function automatic logic [31:0] exp_slot(input logic [31:0] s, input logic [1:0] f, input int dw);
      logic [31:0] w;
      int off;
      w   = '0;
      off = (f == 2'b01) ? 0 : (f == 2'b10) ? 32 - dw : 1;
      for (int i = 0; i < 32; i++)
         if (i >= off && i < off + dw) w[31 - i] = s[dw - 1 - (i - off)];
      return w;
   endfunction

   task automatic drive(input int w, input logic v, input logic [31:0] l, input logic [31:0] r);
      case (w)
         0:       begin sv0 = v; sl0 = l[23:0]; sr0 = r[23:0]; end
         1:       begin sv1 = v; sl1 = l[15:0]; sr1 = r[15:0]; end
         default: begin sv2 = v; sl2 = l[23:0]; sr2 = r[23:0]; end
      endcase
   endtask

   task automatic push_pair(input int w, input logic [31:0] l, input logic [31:0] r, input logic [1:0] f);
      ent_t e;
      e.l = l; e.r = r; e.f = f;
      drive(w, 1'b1, l, r);
      sb.push_back(e);
      @(negedge clk);
      drive(w, 1'b0, 32'h0, 32'h0);
   endtask

   // Wait for a frame pulse, then sample DATA/LRCK on 64 BCK rising edges.
   task automatic capture(input int w, output logic [31:0] lw, output logic [31:0] rw,
                          output logic [63:0] lr, output int n_wait, output int bck_per,
                          output bit ok);
      int k;
      int n;
      int last_rise;
      logic pb;
      lw = '0; rw = '0; lr = '0; n_wait = 0; bck_per = 0; ok = 1'b0;
      for (k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (get_fs(w)) break;
      end
      if (k > 2000) return;
      n_wait  = k;
      fs_prev = fs_last;
      fs_last = $time;
      pb = get_bck(w);
      n = 0;
      last_rise = 0;
      for (int c = 1; c <= 2000 && n < 64; c++) begin
         @(negedge clk);
         if (!pb && get_bck(w)) begin
            if (n < 32) lw = {lw[30:0], get_data(w)};
            else        rw = {rw[30:0], get_data(w)};
            lr = {lr[62:0], get_lrck(w)};
            if (n == 1) bck_per = c - last_rise;
            last_rise = c;
            n++;
         end
         pb = get_bck(w);
      end
      ok = (n == 64);
   endtask

   // Capture one frame and compare it with the scoreboard head (or the underrun model).
   task automatic check_frame(input int w, input string nm, output int n_wait, output int bck_per);
      logic [31:0] lw, rw, el, er;
      logic [63:0] lr;
      bit ok;
      ent_t e;
      int dw;
      capture(w, lw, rw, lr, n_wait, bck_per, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: no complete frame within the cycle bound", nm);
         return;
      end
      dw = (w == 1) ? 16 : 24;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         last_l[w] = e.l; last_r[w] = e.r; last_f[w] = e.f;
      end else if (w == 2) begin
         e.l = last_l[w]; e.r = last_r[w]; e.f = last_f[w];
      end else begin
         e.l = '0; e.r = '0; e.f = last_f[w];
      end
      el = exp_slot(e.l, e.f, dw);
      er = exp_slot(e.r, e.f, dw);
      total++;
      if (lw !== el) begin bad++; $display("FAIL %s left slot: got %h want %h", nm, lw, el); end
      total++;
      if (rw !== er) begin bad++; $display("FAIL %s right slot: got %h want %h", nm, rw, er); end
      total++;
      if (lr !== {32'h0, 32'hFFFF_FFFF}) begin
         bad++; $display("FAIL %s lrck: got %h want %h", nm, lr, {32'h0, 32'hFFFF_FFFF});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({rdy0, lv0, ur0, fs0, lr0, bk0, dt0} !== {1'b1, 3'd0, 5'b0}) begin
         bad++; $display("FAIL reset_dut0: got %b want %b", {rdy0, lv0, ur0, fs0, lr0, bk0, dt0}, {1'b1, 3'd0, 5'b0});
      end
      total++;
      if ({rdy1, lv1, ur1, fs1, lr1, bk1, dt1} !== {1'b1, 3'd0, 5'b0}) begin
         bad++; $display("FAIL reset_dut1: got %b want %b", {rdy1, lv1, ur1, fs1, lr1, bk1, dt1}, {1'b1, 3'd0, 5'b0});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({rdy2, lv2, ur2, fs2, lr2, bk2, dt2} !== {1'b1, 3'd0, 5'b0}) begin
         bad++; $display("FAIL idle_dut2: got %b want %b", {rdy2, lv2, ur2, fs2, lr2, bk2, dt2}, {1'b1, 3'd0, 5'b0});
      end
   endtask

   task automatic test_basic();
      int nw, bp;
      fm0 = 2'b00;
      push_pair(0, 32'h800001, 32'h7FFFFE, 2'b00);
      total++;
      if (lv0 !== 3'd1) begin bad++; $display("FAIL basic_level: got %0d want 1", lv0); end
      en0 = 1'b1;
      check_frame(0, "basic_i2s", nw, bp);
      en0 = 1'b0;
      total++;
      if (nw != 2) begin bad++; $display("FAIL basic_start_latency: got %0d want 2", nw); end
      @(negedge clk);
      total++;
      if ({ur0, lv0} !== 4'b0_000) begin bad++; $display("FAIL basic_underrun_level: got %b want 0000", {ur0, lv0}); end
   endtask

   task automatic test_underrun();
      int nw, bp;
      en0 = 1'b1;
      check_frame(0, "uflow_zero", nw, bp);
      total++;
      if (ur0 !== 1'b1) begin bad++; $display("FAIL uflow_set: got %b want 1", ur0); end
      repeat (20) @(negedge clk);
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      total++;
      if (ur0 !== 1'b0) begin bad++; $display("FAIL uflow_clr: got %b want 0", ur0); end
      push_pair(0, 32'h00ABCD, 32'h123000, 2'b00);
      check_frame(0, "uflow_refill", nw, bp);
      en0 = 1'b0;
      total++;
      if (ur0 !== 1'b0) begin bad++; $display("FAIL uflow_stays_clear: got %b want 0", ur0); end
   endtask

   task automatic test_back_to_back();
      int nw, bp;
      logic [31:0] l;
      ent_t e;
      fm0 = 2'b01;
      for (int i = 0; i < 5; i++) begin
         l = 32'(24'h111111 * (i + 1));
         drive(0, 1'b1, l, l ^ 32'h00FF_FFFF);
         total++;
         if (rdy0 !== ((i < 4) ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL b2b_ready_%0d: got %b want %b", i, rdy0, (i < 4));
         end
         if (i < 4) begin
            e.l = l; e.r = l ^ 32'h00FF_FFFF; e.f = 2'b01;
            sb.push_back(e);
         end
         @(negedge clk);
      end
      drive(0, 1'b0, 32'h0, 32'h0);
      total++;
      if ({rdy0, lv0} !== {1'b0, 3'd4}) begin bad++; $display("FAIL b2b_full: got %b want 0100", {rdy0, lv0}); end
      en0 = 1'b1;
      for (int f = 0; f < 5; f++) begin
         check_frame(0, $sformatf("b2b_frame_%0d", f), nw, bp);
         if (f > 0) begin
            total++;
            if (fs_last - fs_prev != 64'd1280) begin
               bad++; $display("FAIL b2b_period_%0d: got %0d want 1280", f, fs_last - fs_prev);
            end
         end
      end
      en0 = 1'b0;
      total++;
      if (ur0 !== 1'b1) begin bad++; $display("FAIL b2b_underrun: got %b want 1", ur0); end
   endtask

   task automatic test_rj_slow();
      int nw, bp;
      fm1 = 2'b10;
      push_pair(1, 32'hA5A5, 32'h5A5A, 2'b10);
      en1 = 1'b1;
      check_frame(1, "rj16", nw, bp);
      en1 = 1'b0;
      total++;
      if (nw != 6) begin bad++; $display("FAIL rj_start_latency: got %0d want 6", nw); end
      total++;
      if (bp != 6) begin bad++; $display("FAIL rj_bck_period: got %0d want 6", bp); end
   endtask

   task automatic test_repeat();
      int nw, bp;
      fm2 = 2'b00;
      push_pair(2, 32'h123456, 32'h0ABCDE, 2'b00);
      en2 = 1'b1;
      check_frame(2, "rep_first", nw, bp);
      total++;
      if (ur2 !== 1'b0) begin bad++; $display("FAIL rep_no_underrun: got %b want 0", ur2); end
      check_frame(2, "rep_second", nw, bp);
      en2 = 1'b0;
      total++;
      if (ur2 !== 1'b1) begin bad++; $display("FAIL rep_underrun: got %b want 1", ur2); end
   endtask

   task automatic test_reset_mid();
      int k;
      int nw, bp;
      fm0 = 2'b00;
      push_pair(0, 32'hFFFFFF, 32'h000F0F, 2'b00);
      push_pair(0, 32'h111111, 32'h222222, 2'b00);
      en0 = 1'b1;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (fs0) break;
      end
      total++;
      if (k >= 300) begin bad++; $display("FAIL midrst_start: got timeout want frame_start"); end
      repeat (21) @(negedge clk);
      total++;
      if ({bk0, dt0, lv0} !== {1'b1, 1'b1, 3'd1}) begin
         bad++; $display("FAIL midrst_before: got %b want 11001", {bk0, dt0, lv0});
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({lv0, rdy0, fs0, lr0, bk0, dt0, ur0} !== {3'd0, 1'b1, 5'b0}) begin
         bad++; $display("FAIL midrst_async: got %b want 000100000", {lv0, rdy0, fs0, lr0, bk0, dt0, ur0});
      end
      sb.delete();
      for (int i = 0; i < 3; i++) begin last_l[i] = '0; last_r[i] = '0; last_f[i] = '0; end
      @(negedge clk);
      rst_n = 1'b1;
      check_frame(0, "midrst_clean", nw, bp);
      en0 = 1'b0;
      total++;
      if (nw != 2) begin bad++; $display("FAIL midrst_latency: got %0d want 2", nw); end
      total++;
      if (ur0 !== 1'b1) begin bad++; $display("FAIL midrst_underrun: got %b want 1", ur0); end
   endtask

   initial begin
      total = 0; bad = 0;
      fs_last = 0; fs_prev = 0;
      for (int i = 0; i < 3; i++) begin last_l[i] = '0; last_r[i] = '0; last_f[i] = '0; end
      en0 = 0; sv0 = 0; clr0 = 0; fm0 = 0; sl0 = 0; sr0 = 0;
      en1 = 0; sv1 = 0; clr1 = 0; fm1 = 0; sl1 = 0; sr1 = 0;
      en2 = 0; sv2 = 0; clr2 = 0; fm2 = 0; sl2 = 0; sr2 = 0;
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_underrun();
      test_back_to_back();
      test_rj_slow();
      test_repeat();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
